dram_port_arbiter: RTL

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

---
 rtl/dram_port_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single DRAM command port.
// Each requester owns a one-deep slot; a WAIT watchdog completes a stuck access with zero data.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif

module dram_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`MEM_ADDR_BITS-1:0] req0_addr,
  input  logic                      req0_read_en,
  input  logic                      req0_write_en,
  input  logic [`XLEN_BYTES-1:0]    req0_byte_enable,
  input  logic [`XLEN-1:0]          req0_write_data,
  output logic                      req0_ack,
  output logic [`XLEN-1:0]          req0_read_data,
  output logic                      req0_pending,
  input  logic [`MEM_ADDR_BITS-1:0] req1_addr,
  input  logic                      req1_read_en,
  input  logic                      req1_write_en,
  input  logic [`XLEN_BYTES-1:0]    req1_byte_enable,
  input  logic [`XLEN-1:0]          req1_write_data,
  output logic                      req1_ack,
  output logic [`XLEN-1:0]          req1_read_data,
  output logic                      req1_pending,
  output logic [`MEM_ADDR_BITS-1:0] ext_dram_mem_addr,
  output logic                      ext_dram_mem_read_en,
  output logic                      ext_dram_mem_write_en,
  output logic [`XLEN_BYTES-1:0]    ext_dram_mem_byte_enable,
  output logic [`XLEN-1:0]          ext_dram_mem_write_data,
  input  logic                      ext_dram_ack,
  input  logic [`XLEN-1:0]          ext_dram_mem_read_data,
  output logic                      timeout_error
);
  localparam int AW = `MEM_ADDR_BITS;
  localparam int DW = `XLEN;
  localparam int BW = `XLEN_BYTES;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    WAIT  = 3'b100
  } state_t;

  state_t          state_q;
  logic            grant_q;
  logic            last_grant_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            timeout_q;
  logic [1:0]      slot_vld_q;
  logic [1:0]      slot_vld_d;
  logic [1:0]      slot_wr_q;
  logic [AW-1:0]   slot_addr_q [2];
  logic [BW-1:0]   slot_be_q   [2];
  logic [DW-1:0]   slot_data_q [2];
  logic [AW-1:0]   ext_addr_q;
  logic            ext_rd_q;
  logic            ext_wr_q;
  logic [BW-1:0]   ext_be_q;
  logic [DW-1:0]   ext_data_q;

  logic [AW-1:0]   in_addr_s [2];
  logic [BW-1:0]   in_be_s   [2];
  logic [DW-1:0]   in_data_s [2];
  logic [1:0]      in_req_s;
  logic [1:0]      in_wr_s;
  logic [1:0]      clr_s;
  logic [1:0]      cap_s;
  logic            in_wait_s;
  logic            ack_hit_s;
  logic            tmo_s;
  logic            done_s;
  logic            sel_s;

  assign in_addr_s[0] = req0_addr;
  assign in_addr_s[1] = req1_addr;
  assign in_be_s[0]   = req0_byte_enable;
  assign in_be_s[1]   = req1_byte_enable;
  assign in_data_s[0] = req0_write_data;
  assign in_data_s[1] = req1_write_data;
  assign in_req_s     = {req1_read_en | req1_write_en, req0_read_en | req0_write_en};
  assign in_wr_s      = {req1_write_en, req0_write_en};

  // A real ack in the timeout cycle wins over the watchdog.
  assign in_wait_s = (state_q == WAIT) && !reset;
  assign ack_hit_s = in_wait_s && ext_dram_ack;
  assign tmo_s     = in_wait_s && !ext_dram_ack && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign done_s    = ack_hit_s || tmo_s;

  assign req0_ack       = done_s && (grant_q == 1'b0);
  assign req1_ack       = done_s && (grant_q == 1'b1);
  assign req0_read_data = (ack_hit_s && (grant_q == 1'b0)) ? ext_dram_mem_read_data : {DW{1'b0}};
  assign req1_read_data = (ack_hit_s && (grant_q == 1'b1)) ? ext_dram_mem_read_data : {DW{1'b0}};
  assign req0_pending   = slot_vld_q[0];
  assign req1_pending   = slot_vld_q[1];

  assign ext_dram_mem_addr        = ext_addr_q;
  assign ext_dram_mem_read_en     = ext_rd_q;
  assign ext_dram_mem_write_en    = ext_wr_q;
  assign ext_dram_mem_byte_enable = ext_be_q;
  assign ext_dram_mem_write_data  = ext_data_q;
  assign timeout_error            = timeout_q;

  // Slot capture: a slot being released this cycle may be refilled in the same cycle.
  always_comb begin
    clr_s      = 2'b00;
    cap_s      = 2'b00;
    slot_vld_d = slot_vld_q;
    sel_s      = 1'b0;
    for (int n = 0; n < 2; n++) begin
      clr_s[n] = done_s && (grant_q == n[0]);
      cap_s[n] = in_req_s[n] && (!slot_vld_q[n] || clr_s[n]);
      if (cap_s[n]) begin
        slot_vld_d[n] = 1'b1;
      end else if (clr_s[n]) begin
        slot_vld_d[n] = 1'b0;
      end else begin
        slot_vld_d[n] = slot_vld_q[n];
      end
    end
    if (slot_vld_q == 2'b11) begin
      sel_s = ~last_grant_q;
    end else begin
      sel_s = slot_vld_q[1];
    end
  end

  // Arbitration FSM, slots and registered DRAM command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= {CW{1'b0}};
      timeout_q    <= 1'b0;
      slot_vld_q   <= 2'b00;
      slot_wr_q    <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        slot_addr_q[n] <= {AW{1'b0}};
        slot_be_q[n]   <= {BW{1'b0}};
        slot_data_q[n] <= {DW{1'b0}};
      end
      ext_addr_q <= {AW{1'b0}};
      ext_rd_q   <= 1'b0;
      ext_wr_q   <= 1'b0;
      ext_be_q   <= {BW{1'b0}};
      ext_data_q <= {DW{1'b0}};
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (cap_s[n]) begin
          slot_addr_q[n] <= in_addr_s[n];
          slot_be_q[n]   <= in_be_s[n];
          slot_data_q[n] <= in_data_s[n];
          slot_wr_q[n]   <= in_wr_s[n];
        end
      end
      slot_vld_q <= slot_vld_d;
      ext_rd_q   <= 1'b0;
      ext_wr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (slot_vld_q != 2'b00) begin
            grant_q    <= sel_s;
            ext_addr_q <= slot_addr_q[sel_s];
            ext_be_q   <= slot_be_q[sel_s];
            ext_data_q <= slot_data_q[sel_s];
            ext_wr_q   <= slot_wr_q[sel_s];
            ext_rd_q   <= !slot_wr_q[sel_s];
            state_q    <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          last_grant_q <= grant_q;
          wait_cnt_q   <= {CW{1'b0}};
          state_q      <= WAIT;
        end
        WAIT: begin
          if (done_s) begin
            if (tmo_s) begin
              timeout_q <= 1'b1;
            end else begin
              timeout_q <= timeout_q;
            end
            state_q <= IDLE;
          end else if (wait_cnt_q != {CW{1'b1}}) begin
            wait_cnt_q <= wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            wait_cnt_q <= wait_cnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
